// File: rtl/rggen_bit_field_initiator.sv
// Bridges a valid/ready request/response bus onto a single rggen bit field interface.
// Optional macro RGGEN_BIT_FIELD_INITIATOR_DECODE_ERROR_EN reports address misses as errors.
module rggen_bit_field_initiator #(
    parameter int                       ADDRESS_WIDTH    = 8,
    parameter int                       DATA_WIDTH       = 32,
    parameter logic [ADDRESS_WIDTH-1:0] REGISTER_ADDRESS = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_request_valid,
    output logic                      o_request_ready,
    input  logic [ADDRESS_WIDTH-1:0]  i_request_address,
    input  logic                      i_request_write,
    input  logic [DATA_WIDTH-1:0]     i_request_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_request_strobe,
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic [DATA_WIDTH-1:0]     o_response_read_data,
    output logic                      o_response_error,
    output logic                      o_bf_valid,
    output logic [DATA_WIDTH-1:0]     o_bf_read_mask,
    output logic [DATA_WIDTH-1:0]     o_bf_write_mask,
    output logic [DATA_WIDTH-1:0]     o_bf_write_data,
    input  logic [DATA_WIDTH-1:0]     i_bf_read_data
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int LSB          = $clog2(STROBE_WIDTH);
    // Byte-offset bits inside the register word take no part in decoding.
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = {ADDRESS_WIDTH{1'b1}} << LSB;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPONSE
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
    logic                      write_q, write_d;
    logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
    logic [STROBE_WIDTH-1:0]   strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
    logic                      error_q, error_d;
    logic                      hit;

    assign hit = ((address_q ^ REGISTER_ADDRESS) & ADDRESS_MASK) == '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            address_q    <= '0;
            write_q      <= 1'b0;
            write_data_q <= '0;
            strobe_q     <= '0;
            read_data_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            write_q      <= write_d;
            write_data_q <= write_data_d;
            strobe_q     <= strobe_d;
            read_data_q  <= read_data_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        write_d      = write_q;
        write_data_d = write_data_q;
        strobe_d     = strobe_q;
        read_data_d  = read_data_q;
        error_d      = error_q;
        case (state_q)
            IDLE: begin
                if (i_request_valid) begin
                    state_d      = ACCESS;
                    address_d    = i_request_address;
                    write_d      = i_request_write;
                    write_data_d = i_request_write_data;
                    strobe_d     = i_request_strobe;
                end
            end
            ACCESS: begin
                state_d     = RESPONSE;
                read_data_d = (hit && !write_q) ? i_bf_read_data : '0;
`ifdef RGGEN_BIT_FIELD_INITIATOR_DECODE_ERROR_EN
                error_d     = !hit;
`else
                error_d     = 1'b0;
`endif
            end
            RESPONSE: begin
                if (i_response_ready) begin
                    state_d     = IDLE;
                    read_data_d = '0;
                    error_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes exist only during the single ACCESS cycle, so read side effects fire once.
    always_comb begin
        o_bf_valid      = 1'b0;
        o_bf_read_mask  = '0;
        o_bf_write_mask = '0;
        o_bf_write_data = '0;
        if (state_q == ACCESS && hit) begin
            o_bf_valid = 1'b1;
            if (write_q) begin
                for (int i = 0; i < STROBE_WIDTH; i++) begin
                    o_bf_write_mask[i*8 +: 8] = {8{strobe_q[i]}};
                end
                o_bf_write_data = write_data_q;
            end else begin
                o_bf_read_mask = '1;
            end
        end
    end

    assign o_request_ready      = (state_q == IDLE) && i_rst_n;
    assign o_response_valid     = (state_q == RESPONSE);
    assign o_response_read_data = read_data_q;
    assign o_response_error     = error_q;

endmodule
